// File: rtl/hps_pio_pkg.sv
// Shared register-map and edge-type constants for the HPS input PIO.
// Also provides the lane mask that keeps bits above WIDTH at zero.
package hps_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic logic [31:0] lane_mask(input int width);
        logic [31:0] mask;
        if (width >= 32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Three-stage input synchronizer with a post-reset prime counter and
// per-bit edge vector generation for the HPS input PIO.
module pio_sync_edge
    import hps_pio_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_in,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_edge
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;
    logic [1:0]       r_prime;
    logic [WIDTH-1:0] w_edge_raw;

    // NOTE: non-blocking assignments make each stage take the previous
    // stage's old value; blocking here would collapse the chain to one flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Edges stay suppressed until s3 holds a genuine post-reset sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prime <= 2'd0;
        end else if (r_prime != 2'd3) begin
            r_prime <= r_prime + 2'd1;
        end
    end

    // NOTE: assigning a default first means every path writes the output,
    // so no latch is inferred even if a case arm is missed.
    always_comb begin
        w_edge_raw = r_s2 & ~r_s3;
        case (EDGE_TYPE)
            EDGE_FALL: w_edge_raw = ~r_s2 & r_s3;
            EDGE_ANY:  w_edge_raw = r_s2 ^ r_s3;
            default:   w_edge_raw = r_s2 & ~r_s3;
        endcase
    end

    assign o_sync = r_s2;
    assign o_edge = (r_prime == 2'd3) ? w_edge_raw : '0;

endmodule

// File: rtl/hps_pio_in.sv
// Avalon-MM input PIO: synchronized DATA, IRQMASK, W1C EDGECAP and a
// level interrupt for unmasked captured edges. Read latency is one clock.
module hps_pio_in
    import hps_pio_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [31:0] LANE_MASK = lane_mask(WIDTH);

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [31:0]      w_sync32;
    logic [31:0]      w_edge32;
    logic [31:0]      w_clr;
    logic [31:0]      w_rdmux;
    logic             w_wr;

    logic [31:0]      r_irqmask;
    logic [31:0]      r_edgecap;
    logic [31:0]      r_readdata;

    pio_sync_edge #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .i_in   (in_port),
        .o_sync (w_sync),
        .o_edge (w_edge)
    );

    // Registers are kept 32 bits wide; lanes above WIDTH are constant zero.
    always_comb begin
        w_sync32            = '0;
        w_edge32            = '0;
        w_sync32[WIDTH-1:0] = w_sync;
        w_edge32[WIDTH-1:0] = w_edge;
    end

    assign w_wr  = chipselect && !write_n;
    assign w_clr = (w_wr && address == ADDR_EDGECAP) ? writedata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
        end else if (w_wr && address == ADDR_IRQMASK) begin
            r_irqmask <= writedata & LANE_MASK;
        end
    end

    // Set wins over clear so an edge coincident with W1C is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge32;
        end
    end

    always_comb begin
        w_rdmux = '0;
        case (address)
            ADDR_DATA:    w_rdmux = w_sync32;
            ADDR_IRQMASK: w_rdmux = r_irqmask;
            ADDR_EDGECAP: w_rdmux = r_edgecap;
            default:      w_rdmux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (chipselect) begin
            r_readdata <= w_rdmux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_hps_pio_in.sv
// Directed scoreboard bench for hps_pio_in (WIDTH=10, rising edges).
// Expected read data is queued when a read is issued and popped one clock later.
module tb_hps_pio_in;

    localparam int W = 10;

    logic         clk;
    logic         reset;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic         irq;

    int n_tests;
    int n_fail;
    logic [31:0] exp_q[$];

    hps_pio_in #(
        .WIDTH     (W),
        .EDGE_TYPE (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        exp_q.push_back(exp);
        tick();
        chipselect = 1'b0;
        address    = 2'd2;
        check(tag, readdata, exp_q.pop_front());
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = '0;
        in_port    = 10'h3FF;

        // Reset with inputs high: nothing may be captured as an edge.
        tick(3);
        check("irq_in_reset", {31'd0, irq}, 32'd0);
        check("rd_in_reset", readdata, 32'd0);
        reset = 1'b0;
        tick(10);
        rd(2'd3, 32'h000, "prime_edgecap");
        check("prime_irq", {31'd0, irq}, 32'd0);
        rd(2'd0, 32'h3FF, "data_after_reset");

        // readdata holds while chipselect is low.
        tick(2);
        check("rd_hold", readdata, 32'h3FF);

        // Rising edge on bit0 with bit0 unmasked.
        wr(2'd1, 32'h001);
        rd(2'd1, 32'h001, "irqmask_rd");
        in_port = 10'h3FE;
        tick(5);
        rd(2'd3, 32'h000, "fall_not_captured");
        in_port = 10'h3FF;
        tick();                                  // T0: sampled into s1
        check("edge_irq_T0", {31'd0, irq}, 32'd0);
        tick();                                  // T1: edge computed
        check("edge_irq_T1", {31'd0, irq}, 32'd0);
        tick();                                  // T2: EDGECAP sets
        check("edge_irq_T2", {31'd0, irq}, 32'd1);
        rd(2'd3, 32'h001, "edgecap_bit0");

        // W1C semantics.
        wr(2'd3, 32'h000);
        rd(2'd3, 32'h001, "w1c_zero_noop");
        check("w1c_zero_irq", {31'd0, irq}, 32'd1);
        wr(2'd3, 32'h001);
        check("w1c_irq_drop", {31'd0, irq}, 32'd0);
        rd(2'd3, 32'h000, "w1c_cleared");

        // Bit3 edge coincident with a W1C of bit3: set wins.
        in_port = 10'h3F7;
        tick(5);
        in_port = 10'h3FF;
        tick(2);
        wr(2'd3, 32'h008);
        rd(2'd3, 32'h008, "set_wins_over_clear");
        wr(2'd3, 32'h008);
        rd(2'd3, 32'h000, "bit3_cleared");

        // All bits edge with everything masked.
        wr(2'd1, 32'h000);
        in_port = 10'h000;
        tick(5);
        in_port = 10'h3FF;
        tick(4);
        rd(2'd3, 32'h3FF, "all_edges");
        check("masked_irq", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'h200);
        check("unmask_irq", {31'd0, irq}, 32'd1);

        // Reserved address and bits above WIDTH.
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'h000, "reserved_rd");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h3FF, "irqmask_upper");
        wr(2'd0, 32'h0000_0000);
        rd(2'd0, 32'h3FF, "data_ro");
        wr(2'd3, 32'hFFFF_FFFF);
        check("clear_all_irq", {31'd0, irq}, 32'd0);
        rd(2'd3, 32'h000, "clear_all");

        // Asynchronous reset mid-operation, then the prime window again.
        in_port = 10'h000;
        tick(5);
        in_port = 10'h3FF;
        tick(4);
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_irq", {31'd0, irq}, 32'd0);
        check("async_rd", readdata, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(10);
        rd(2'd3, 32'h000, "reprime_edgecap");
        rd(2'd1, 32'h000, "reprime_irqmask");
        rd(2'd0, 32'h3FF, "reprime_data");

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
